pipe_alu_fwd: RTL and testbench
===============================

Name: pipe_alu_fwd

Overview:
- Parametrised 4-stage register-file ALU pipeline: operand read, execute, register writeback, memory store.
- Single-clock successor to the two-phase-clock pipe ALU.
- Adds valid qualification, full operand forwarding (no stalls on RAW hazards) and configurable widths/depths.
- Sits as the datapath core under the ADLD pipeline exercises and their benches.

Parameters:
DW, 16, data width of register bank, memory and ALU
REG_AW, 4, register address width (2**REG_AW registers)
MEM_AW, 8, memory address width (2**MEM_AW words)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  instruction present on rs1/rs2/rd/func/addr this cycle
rs1  in  REG_AW  source register A
rs2  in  REG_AW  source register B
rd  in  REG_AW  destination register
func  in  4  ALU operation code
addr  in  MEM_AW  memory word written with the result
zout  out  DW  registered result of the instruction in writeback
zout_valid  out  1  zout carries a valid result
dbg_addr  in  MEM_AW  combinational memory read address
dbg_data  out  DW  mem[dbg_addr], combinational

Behaviour:
- Storage: internal arrays named regbank and mem, not reset. Benches preload them hierarchically.
- Stages: S1 latches operands A/B plus rd, func, addr and valid. S2 latches the ALU result. S3 writes regbank and drives zout. S4 writes mem.
- Timing: an instruction sampled at edge e0 computes at e1. At e2 it writes regbank[rd], and zout/zout_valid update. At e3 it writes mem[addr].
- Throughput: one instruction per cycle. in_valid=0 inserts a bubble; bubbles perform no writes.
- Forwarding: when sampling rs1/rs2 at edge e, operand priority is:
  1. Combinational ALU output of a valid S1 instruction with a matching rd.
  2. Registered S2 result with a matching rd.
  3. regbank.
- Forwarding always yields the architecturally newest value. No stalls, no ready signal.
- Same-edge conflicts: S3 regbank write and S1 read in the same edge are covered by the S2 forward path. When S3 and S4 target the same mem address, the later instruction wins.
- func codes:
  - 0 add, 1 sub (A-B), 2 mul (low DW bits), 3 pass A, 4 pass B
  - 5 and, 6 or, 7 xor, 8 -A, 9 -B
  - 10 A>>1 logical, 11 A<<1, 12-15 reserved → result 0 (still written).
- Arithmetic: modulo 2**DW. rd/addr wider values in the bench are truncated to port width (rd=16 with REG_AW=4 targets r0).
- Reset: zout=0, zout_valid=0, all stage valids cleared. In-flight instructions are discarded and perform no regbank or mem writes. Array contents are untouched. Activity resumes on the first edge after rst deasserts.

Optional Feature:
- Macro PIPE_ALU_SAT_EN.
- Defined: add, sub and mul saturate as unsigned. Add/mul overflow → all-ones; sub underflow → 0. Forwarded values are the saturated ones.
- Undefined: wrap-around modulo 2**DW. Logic is identical otherwise.

Decomposition:
- Package pipe_alu_pkg: func code localparams (FN_ADD..FN_SLL), and a function alu_op(func,a,b) parametrised on DW, containing the SAT_EN ifdef.
- Sub-module pipe_alu_exec: the combinational ALU, instantiated once. Its output feeds both the S2 register and the S1-forward mux.

Test Plan:
- Preload regbank[k]=k, mem=0. Issue add rs1=3 rs2=5 rd=10 addr=125 → zout=8 with zout_valid two edges after issue; mem[125]=8 after the third edge; regbank[10]=8.
- Back-to-back RAW, S1 forward path: mul r12=r3*r8 (addr 126), then next cycle add r14=r12+r1 (addr 127) → zout 24 then 25; mem[126]=24, mem[127]=25.
- One-gap RAW, S2 forward path: sub r10=r10-r5 (initial r10=10), bubble, then sub r15=r10-r5 → 5 then 0; mem[129]=0.
- Shifts and reserved codes:
  - func=11 on r7 → 14
  - func=10 on r7 → 3
  - func=13 → 0 written to rd and mem
  - rd=16 writes r0.
- Overflow: poke r2=0xFFFF, add r2+r3 → 0x0002 without PIPE_ALU_SAT_EN, 0xFFFF with it. sub r3-r5 → 0xFFFE wrapped, 0 saturated.
- Reset mid-flight: issue 3 instructions, assert rst one edge later for 2 cycles → zout=0, zout_valid=0 immediately; no mem/regbank change; next instruction after release behaves per the first scenario.

Source files
------------

// File: rtl/pipe_alu_pkg.sv
// Shared func codes and the ALU operation for the forwarding pipe ALU.
// PIPE_ALU_SAT_EN selects unsigned saturating add/sub/mul instead of wrap-around.
package pipe_alu_pkg;

  localparam int unsigned MAX_DW = 64;

  localparam logic [3:0] FN_ADD  = 4'd0;
  localparam logic [3:0] FN_SUB  = 4'd1;
  localparam logic [3:0] FN_MUL  = 4'd2;
  localparam logic [3:0] FN_PA   = 4'd3;
  localparam logic [3:0] FN_PB   = 4'd4;
  localparam logic [3:0] FN_AND  = 4'd5;
  localparam logic [3:0] FN_OR   = 4'd6;
  localparam logic [3:0] FN_XOR  = 4'd7;
  localparam logic [3:0] FN_NEGA = 4'd8;
  localparam logic [3:0] FN_NEGB = 4'd9;
  localparam logic [3:0] FN_SRL  = 4'd10;
  localparam logic [3:0] FN_SLL  = 4'd11;

  // Operands arrive zero-extended to MAX_DW; the result is masked back to dw bits.
  function automatic logic [MAX_DW-1:0] alu_op(input logic [3:0] func,
                                               input logic [MAX_DW-1:0] a,
                                               input logic [MAX_DW-1:0] b,
                                               input int unsigned dw);
    logic [MAX_DW-1:0] mask;
    logic [MAX_DW-1:0] r;
`ifdef PIPE_ALU_SAT_EN
    logic [2*MAX_DW-1:0] wide;
    wide = '0;
`endif
    mask = (dw >= MAX_DW) ? '1 : ((MAX_DW'(1) << dw) - MAX_DW'(1));
    r    = '0;
    case (func)
`ifdef PIPE_ALU_SAT_EN
      FN_ADD: begin
        wide = {{MAX_DW{1'b0}}, a} + {{MAX_DW{1'b0}}, b};
        r    = ((wide >> dw) != '0) ? '1 : wide[MAX_DW-1:0];
      end
      FN_SUB:  r = (b > a) ? '0 : (a - b);
      FN_MUL: begin
        wide = {{MAX_DW{1'b0}}, a} * {{MAX_DW{1'b0}}, b};
        r    = ((wide >> dw) != '0) ? '1 : wide[MAX_DW-1:0];
      end
`else
      FN_ADD:  r = a + b;
      FN_SUB:  r = a - b;
      FN_MUL:  r = a * b;
`endif
      FN_PA:   r = a;
      FN_PB:   r = b;
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      FN_XOR:  r = a ^ b;
      FN_NEGA: r = '0 - a;
      FN_NEGB: r = '0 - b;
      FN_SRL:  r = a >> 1;
      FN_SLL:  r = a << 1;
      default: r = '0;
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/pipe_alu_exec.sv
// Combinational ALU; feeds both the S2 result register and the S1 forward path.
module pipe_alu_exec
  import pipe_alu_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [3:0]    func,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  logic [MAX_DW-1:0] full;

  always_comb begin
    full = alu_op(func, MAX_DW'(a), MAX_DW'(b), DW);
    y    = full[DW-1:0];
  end

endmodule

// File: rtl/pipe_alu_fwd.sv
// Four-stage register-file ALU pipeline (read, execute, writeback, store) with full
// operand forwarding. Saturating arithmetic via PIPE_ALU_SAT_EN (see pipe_alu_pkg).
module pipe_alu_fwd
  import pipe_alu_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [3:0]        func,
  input  logic [MEM_AW-1:0] addr,
  output logic [DW-1:0]     zout,
  output logic              zout_valid,
  input  logic [MEM_AW-1:0] dbg_addr,
  output logic [DW-1:0]     dbg_data
);

  localparam int unsigned NREG = 2 ** REG_AW;
  localparam int unsigned NMEM = 2 ** MEM_AW;

  logic [DW-1:0] regbank [NREG];
  logic [DW-1:0] mem     [NMEM];

  logic              s1_valid;
  logic [DW-1:0]     s1_a;
  logic [DW-1:0]     s1_b;
  logic [REG_AW-1:0] s1_rd;
  logic [3:0]        s1_func;
  logic [MEM_AW-1:0] s1_addr;

  logic              s2_valid;
  logic [DW-1:0]     s2_res;
  logic [REG_AW-1:0] s2_rd;
  logic [MEM_AW-1:0] s2_addr;

  logic [MEM_AW-1:0] s3_addr;

  logic [DW-1:0] exec_y;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  pipe_alu_exec #(
    .DW (DW)
  ) u_exec (
    .func (s1_func),
    .a    (s1_a),
    .b    (s1_b),
    .y    (exec_y)
  );

  // Later overrides win: the instruction in S1 is newer than the one in S2,
  // which in turn is newer than regbank (it writes regbank on this same edge).
  always_comb begin
    op_a = regbank[rs1];
    op_b = regbank[rs2];
    if (s2_valid && (s2_rd == rs1)) op_a = s2_res;
    if (s2_valid && (s2_rd == rs2)) op_b = s2_res;
    if (s1_valid && (s1_rd == rs1)) op_a = exec_y;
    if (s1_valid && (s1_rd == rs2)) op_b = exec_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_rd      <= '0;
      s1_func    <= '0;
      s1_addr    <= '0;
      s2_valid   <= 1'b0;
      s2_res     <= '0;
      s2_rd      <= '0;
      s2_addr    <= '0;
      zout       <= '0;
      zout_valid <= 1'b0;
      s3_addr    <= '0;
    end else begin
      s1_valid   <= in_valid;
      s1_a       <= op_a;
      s1_b       <= op_b;
      s1_rd      <= rd;
      s1_func    <= func;
      s1_addr    <= addr;
      s2_valid   <= s1_valid;
      s2_res     <= exec_y;
      s2_rd      <= s1_rd;
      s2_addr    <= s1_addr;
      zout_valid <= s2_valid;
      if (s2_valid) begin
        zout    <= s2_res;
        s3_addr <= s2_addr;
      end
    end
  end

  // Storage is never reset; reset only clears the valids that gate these writes.
  always_ff @(posedge clk) begin
    if (s2_valid) regbank[s2_rd] <= s2_res;
    if (zout_valid) mem[s3_addr] <= zout;
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_pipe_alu_fwd.sv
// Bench for pipe_alu_fwd: directed scenarios plus random traffic against an
// in-order architectural model (no pipeline in the model).
module tb_pipe_alu_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr, dbg_addr;
  logic [15:0] zout, dbg_data;
  logic        zout_valid;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_reg [16];
  logic [15:0] m_mem [256];
  bit          hv [$];
  logic [15:0] hr [$];

  always #5 clk = ~clk;

  pipe_alu_fwd #(
    .DW     (16),
    .REG_AW (4),
    .MEM_AW (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .func       (func),
    .addr       (addr),
    .zout       (zout),
    .zout_valid (zout_valid),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  function automatic logic [15:0] ref_alu(input int f, input longint a, input longint b);
    longint r;
    case (f)
      0: begin
        r = a + b;
`ifdef PIPE_ALU_SAT_EN
        if (r > 65535) r = 65535;
`endif
      end
      1: begin
        r = a - b;
`ifdef PIPE_ALU_SAT_EN
        if (r < 0) r = 0;
`endif
      end
      2: begin
        r = a * b;
`ifdef PIPE_ALU_SAT_EN
        if (r > 65535) r = 65535;
`endif
      end
      3:  r = a;
      4:  r = b;
      5:  r = a & b;
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = -a;
      9:  r = -b;
      10: r = a / 2;
      11: r = a * 2;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input int a1, input int a2, input int d, input int f,
                       input int ad);
    in_valid = v;
    rs1      = a1[3:0];
    rs2      = a2[3:0];
    rd       = d[3:0];
    func     = f[3:0];
    addr     = ad[7:0];
  endtask

  // One clock: issue (or bubble), update the model in program order, check writeback.
  task automatic step(input bit v, input int a1, input int a2, input int d, input int f,
                      input int ad);
    logic [15:0] res;
    res = '0;
    drive(v, a1, a2, d, f, ad);
    if (v) begin
      res         = ref_alu(int'(func), longint'(m_reg[rs1]), longint'(m_reg[rs2]));
      m_reg[rd]   = res;
      m_mem[addr] = res;
    end
    hv.push_back(v);
    hr.push_back(res);
    @(posedge clk);
    #1;
    chk("zout_valid", 64'(zout_valid), 64'(hv[hv.size()-3]));
    if (hv[hv.size()-3]) chk("zout", 64'(zout), 64'(hr[hr.size()-3]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic hist_clear();
    hv.delete();
    hr.delete();
    for (int i = 0; i < 2; i++) begin
      hv.push_back(1'b0);
      hr.push_back(16'h0);
    end
  endtask

  task automatic poke(input int r, input logic [15:0] v);
    dut.regbank[r] = v;
    m_reg[r]       = v;
  endtask

  task automatic mem_chk(input string tag, input int a, input logic [15:0] exp);
    dbg_addr = a[7:0];
    #1;
    chk(tag, 64'(dbg_data), 64'(exp));
  endtask

  task automatic full_cmp(input string tag);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s reg[%0d]", tag, k), 64'(dut.regbank[k]), 64'(m_reg[k]));
    for (int a = 0; a < 256; a++) mem_chk($sformatf("%s mem[%0d]", tag, a), a, m_mem[a]);
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    dbg_addr = '0;
    drive(1'b0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      dut.regbank[k] = 16'(k);
      m_reg[k]       = 16'(k);
    end
    for (int a = 0; a < 256; a++) begin
      dut.mem[a] = '0;
      m_mem[a]   = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_zout", 64'(zout), 64'h0);
    chk("rst_zout_valid", 64'(zout_valid), 64'h0);
    rst = 1'b0;
    hist_clear();

    // Basic add with explicit writeback/store timing.
    step(1'b1, 3, 5, 10, 0, 125);
    step(1'b0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0);
    chk("s1_zout", 64'(zout), 64'd8);
    chk("s1_zv", 64'(zout_valid), 64'd1);
    mem_chk("s1_mem_early", 125, 16'd0);
    step(1'b0, 0, 0, 0, 0, 0);
    mem_chk("s1_mem", 125, 16'd8);
    chk("s1_reg", 64'(dut.regbank[10]), 64'd8);

    // Back-to-back RAW through the S1 forward.
    step(1'b1, 3, 8, 12, 2, 126);
    step(1'b1, 12, 1, 14, 0, 127);
    idle(4);
    mem_chk("fwd1_a", 126, 16'd24);
    mem_chk("fwd1_b", 127, 16'd25);

    // One-gap RAW through the S2 forward.
    poke(10, 16'd10);
    step(1'b1, 10, 5, 10, 1, 128);
    step(1'b0, 0, 0, 0, 0, 0);
    step(1'b1, 10, 5, 15, 1, 129);
    idle(4);
    mem_chk("fwd2_a", 128, 16'd5);
    mem_chk("fwd2_b", 129, 16'd0);
    chk("fwd2_reg", 64'(dut.regbank[15]), 64'd0);

    // Shifts, reserved code, rd truncation.
    step(1'b1, 7, 0, 4, 11, 130);
    step(1'b1, 7, 0, 6, 10, 131);
    step(1'b1, 0, 0, 9, 13, 125);
    step(1'b1, 7, 0, 16, 3, 132);
    idle(4);
    mem_chk("sll", 130, 16'd14);
    mem_chk("srl", 131, 16'd3);
    mem_chk("rsvd_mem", 125, 16'd0);
    chk("rsvd_reg", 64'(dut.regbank[9]), 64'd0);
    chk("rd16_r0", 64'(dut.regbank[0]), 64'd7);

    // Overflow / underflow.
    poke(2, 16'hFFFF);
    step(1'b1, 2, 3, 11, 0, 133);
    step(1'b1, 3, 5, 13, 1, 134);
    idle(4);
`ifdef PIPE_ALU_SAT_EN
    mem_chk("ovf_add", 133, 16'hFFFF);
    mem_chk("ovf_sub", 134, 16'h0000);
`else
    mem_chk("ovf_add", 133, 16'h0002);
    mem_chk("ovf_sub", 134, 16'hFFFE);
`endif

    // Reset while three instructions are in flight: none may write anything.
    step(1'b1, 7, 7, 8, 0, 135);
    idle(4);
    drive(1'b1, 1, 2, 1, 0, 200);
    @(posedge clk);
    #1;
    drive(1'b1, 3, 3, 2, 2, 201);
    @(posedge clk);
    #1;
    drive(1'b1, 4, 4, 3, 0, 202);
    rst = 1'b1;
    #1;
    chk("midrst_zout", 64'(zout), 64'h0);
    chk("midrst_zv", 64'(zout_valid), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    hist_clear();
    idle(4);
    full_cmp("midrst");
    step(1'b1, 3, 5, 10, 0, 125);
    step(1'b0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0);
    chk("post_rst_zout", 64'(zout), 64'd8);
    step(1'b0, 0, 0, 0, 0, 0);
    mem_chk("post_rst_mem", 125, 16'd8);

    // Random traffic with dense register reuse.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 255)));
    idle(4);
    full_cmp("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
